// File: rtl/alu_exe.sv
// Execute-stage ALU with registered result and architectural HI/LO pair.
// Define MULT_DIV_EN to add the two-cycle MULT/MULTU path.
module alu_exe #(
    parameter int DW  = 32,
    parameter int SAW = 5
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           stall,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     alucontrolE,
    input  logic [DW-1:0]  srca,
    input  logic [DW-1:0]  srcb,
    input  logic [SAW-1:0] sa,
    output logic           out_valid,
    output logic [DW-1:0]  aluout,
    output logic           overflow,
    output logic [DW-1:0]  hi_o,
    output logic [DW-1:0]  lo_o
);

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_LUI_OP  = 8'b0101_1100;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SLLV_OP = 8'b0000_0100;
    localparam logic [7:0] EXE_SRLV_OP = 8'b0000_0110;
    localparam logic [7:0] EXE_SRAV_OP = 8'b0000_0111;
    localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;

    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [DW-1:0] res;
    logic          ovf;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic          accept;
    logic          mul_start;
    logic          mul_busy;
    logic [2*DW-1:0] prod;

    assign accept = in_valid & in_ready & ~stall & ~flush;
    assign sum    = srca + srcb;
    assign diff   = srca - srcb;
    assign hi_o   = hi;
    assign lo_o   = lo;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (alucontrolE)
            EXE_AND_OP:  res = srca & srcb;
            EXE_OR_OP:   res = srca | srcb;
            EXE_XOR_OP:  res = srca ^ srcb;
            EXE_NOR_OP:  res = ~(srca | srcb);
            EXE_LUI_OP:  res = {srcb[15:0], {(DW-16){1'b0}}};
            EXE_SLL_OP:  res = srcb << sa;
            EXE_SRL_OP:  res = srcb >> sa;
            EXE_SRA_OP:  res = $signed(srcb) >>> sa;
            EXE_SLLV_OP: res = srcb << srca[SAW-1:0];
            EXE_SRLV_OP: res = srcb >> srca[SAW-1:0];
            EXE_SRAV_OP: res = $signed(srcb) >>> srca[SAW-1:0];
            EXE_ADD_OP: begin
                res = sum;
                ovf = (srca[DW-1] == srcb[DW-1]) &&
                      (sum[DW-1] != srca[DW-1]);
            end
            EXE_SUB_OP: begin
                res = diff;
                ovf = (srca[DW-1] != srcb[DW-1]) &&
                      (diff[DW-1] != srca[DW-1]);
            end
            EXE_SLT_OP:  res = {{(DW-1){1'b0}},
                                $signed(srca) < $signed(srcb)};
            EXE_MFHI_OP: res = hi;
            EXE_MFLO_OP: res = lo;
            EXE_MTHI_OP, EXE_MTLO_OP, EXE_NOP_OP: res = '0;
            default:     res = '0;
        endcase
    end

`ifdef MULT_DIV_EN
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;

    typedef enum logic {IDLE, MUL1} state_t;
    state_t state, state_nxt;
    logic [DW:0] mul_a;
    logic [DW:0] mul_b;
    logic        is_mult;
    logic        is_multu;

    assign is_mult   = alucontrolE == EXE_MULT_OP;
    assign is_multu  = alucontrolE == EXE_MULTU_OP;
    assign mul_start = accept & (is_mult | is_multu);
    assign mul_busy  = state == MUL1;
    assign in_ready  = state == IDLE;
    // 33-bit sign/zero-extended operands make one signed multiply serve both ops
    assign prod      = $signed(mul_a) * $signed(mul_b);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                mul_a <= {is_mult & srca[DW-1], srca};
                mul_b <= {is_mult & srcb[DW-1], srcb};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (!stall) begin
            unique case (state)
                IDLE:    if (mul_start) state_nxt = MUL1;
                MUL1:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end
`else
    assign mul_start = 1'b0;
    assign mul_busy  = 1'b0;
    assign in_ready  = 1'b1;
    assign prod      = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            aluout    <= '0;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (mul_busy) begin
                hi        <= prod[2*DW-1:DW];
                lo        <= prod[DW-1:0];
                out_valid <= 1'b1;
                aluout    <= '0;
                overflow  <= 1'b0;
            end else if (accept) begin
                // a multiply reports valid only once its product lands
                out_valid <= ~mul_start;
                aluout    <= res;
                overflow  <= ovf;
                if (alucontrolE == EXE_MTHI_OP) hi <= srca;
                if (alucontrolE == EXE_MTLO_OP) lo <= srca;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_exe.md
Name: alu_exe

Overview:
- Execute-stage consumer of the 8-bit alucontrol code produced by the decode-stage ALU decoder.
- Accepts one operation per cycle, computes the result, and registers it with one-cycle latency.
- Owns the architectural HI/LO register pair, written by MTHI/MTLO and read by MFHI/MFLO.
- Sits between the ID/EX pipeline register and the EX/MEM register.
- Honours the pipeline stall and flush controls from the hazard unit.

Parameters:
- DW, 32: operand and result width.
- SAW, 5: shift-amount width.

Ports:
- clk  in  1  Rising-edge clock.
- resetn  in  1  Asynchronous, active-low reset.
- stall  in  1  Hold stage. No new op is accepted and outputs hold.
- flush  in  1  Kill the op presented this cycle and clear out_valid.
- in_valid  in  1  Op present on alucontrolE/srca/srcb/sa.
- in_ready  out  1  Block can accept an op this cycle.
- alucontrolE  in  8  Op code, using the `EXE_*_OP values from defines.vh.
- srca  in  DW  rs operand.
- srcb  in  DW  rt operand or extended immediate.
- sa  in  SAW  instr[10:6] shift amount.
- out_valid  out  1  aluout/overflow are valid.
- aluout  out  DW  Registered result.
- overflow  out  1  Signed overflow on ADD/SUB.
- hi_o  out  DW  Current HI.
- lo_o  out  DW  Current LO.

Behaviour:
- Reset (resetn=0, async): out_valid=0, aluout=0, overflow=0, HI=0, LO=0, in_ready=1, FSM=IDLE.
- Accept condition: in_valid & in_ready & ~stall & ~flush. On the next rising edge: out_valid=1 and aluout/overflow are updated.
- No accepted op on an edge: out_valid=0 on that edge, unless stall=1, in which case out_valid, aluout and overflow hold their values.
- flush=1 has priority over stall:
  - out_valid goes to 0 on the next edge.
  - The presented op has no HI/LO side effect.
- Result rules:
  - AND/OR/XOR/NOR: bitwise on srca, srcb.
  - LUI: {srcb[15:0],16'h0}.
  - SLL/SRL/SRA: srcb shifted by sa. SRA is arithmetic.
  - SLLV/SRLV/SRAV: srcb shifted by srca[4:0].
  - ADD: srca+srcb. SUB: srca-srcb. overflow=1 iff the signed result overflows; aluout still carries the wrapped sum.
  - SLT: signed compare, result 1 or 0.
  - MFHI/MFLO: aluout = HI/LO value as of the accept edge.
  - MTHI/MTLO: HI/LO <= srca on the accept edge; aluout=0.
  - NOP or unknown code: aluout=0, overflow=0, out_valid still 1.
- overflow is 0 for every op other than ADD/SUB.
- Back-to-back MTHI then MFHI on consecutive accepted cycles: MFHI returns the new value, with no extra bypass needed.
- FSM: IDLE is the only state unless MULT_DIV_EN is set (see Optional Feature).

Optional Feature:
- Macro: MULT_DIV_EN.
- When defined, MULT/MULTU are supported and add FSM states IDLE -> MUL1 -> IDLE:
  - On accept, the FSM enters MUL1 and in_ready=0 for exactly one cycle. The product is formed over two cycles, signed for MULT and unsigned for MULTU.
  - On leaving MUL1: {HI,LO} <= 64-bit product, out_valid=1, aluout=0.
  - stall in MUL1 freezes the FSM.
  - flush in MUL1 aborts: FSM returns to IDLE, out_valid=0, HI/LO unchanged.
  - resetn asserted in MUL1 returns the FSM to IDLE with HI/LO=0.
- When not defined, MULT/MULTU decode as unknown codes and in_ready is tied to 1.

Test Plan:
- Reset, then ADD srca=32'h7FFFFFFF, srcb=1 -> next cycle out_valid=1, aluout=32'h80000000, overflow=1.
- SRA srcb=32'hF0000000, sa=4 -> aluout=32'hFF000000. SRLV srca=36, srcb=32'h80 -> aluout=32'h8 (shift 4).
- MTHI srca=32'hDEADBEEF then MFHI on the next cycle -> aluout=32'hDEADBEEF, hi_o=32'hDEADBEEF.
- MTLO srca=5 presented with flush=1 -> out_valid=0 next cycle, lo_o unchanged (0).
- SLT srca=-1, srcb=1 -> aluout=1. Then stall=1 for 3 cycles -> aluout=1 and out_valid=1 held, a new op on the inputs is ignored.
- MULT_DIV_EN: MULT srca=-2, srcb=3 -> in_ready=0 for 1 cycle, then out_valid=1, HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. resetn pulsed during MUL1 -> FSM IDLE, HI=LO=0.
